// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - two-operand loader FSM feeding an external add/subtract unit
// Optional macro OPERAND_LOADER_LOAD_EDGE_EN: load acts on its rising edge instead of its level.
module operand_loader #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         data_in,
  input  logic               op_in,
  input  logic               load,
  input  logic               clear,
  output logic [3:0]         a_out,
  output logic [3:0]         b_out,
  output logic               op_out,
  input  logic [4:0]         r_in,
  input  logic               ovf_in,
  input  logic               zero_in,
  input  logic               sinal_in,
  output logic [4:0]         result,
  output logic               overflow,
  output logic               zero,
  output logic               sinal,
  output logic               valid,
  output logic [1:0]         state,
  output logic [COUNT_W-1:0] op_count
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] HAVE_A = 2'b01;
  localparam logic [1:0] EXEC   = 2'b10;
  localparam logic [1:0] DONE   = 2'b11;

  logic load_evt;

`ifdef OPERAND_LOADER_LOAD_EDGE_EN
  logic load_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) load_d <= 1'b0;
    else     load_d <= load;
  end

  assign load_evt = load & ~load_d;
`else
  assign load_evt = load;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_out    <= 4'd0;
      b_out    <= 4'd0;
      op_out   <= 1'b0;
      result   <= 5'd0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      sinal    <= 1'b0;
      valid    <= 1'b0;
      op_count <= '0;
    end else if (clear) begin
      // Abort in any state; the completed-operation count survives.
      state    <= IDLE;
      a_out    <= 4'd0;
      b_out    <= 4'd0;
      op_out   <= 1'b0;
      result   <= 5'd0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      sinal    <= 1'b0;
      valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_evt) begin
            a_out <= data_in;
            state <= HAVE_A;
          end
        end
        HAVE_A: begin
          if (load_evt) begin
            b_out  <= data_in;
            op_out <= op_in;
            state  <= EXEC;
          end
        end
        EXEC: begin
          // The downstream unit has had a full cycle to settle on a_out/b_out/op_out.
          result   <= r_in;
          overflow <= ovf_in;
          zero     <= zero_in;
          sinal    <= sinal_in;
          valid    <= 1'b1;
          op_count <= op_count + COUNT_W'(1);
          state    <= DONE;
        end
        default: begin
          if (load_evt) begin
            a_out <= data_in;
            valid <= 1'b0;
            state <= HAVE_A;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 SHALL have parameter COUNT_W, default 8: width of the completed-operation counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port data_in  input  4  operand value from switches.
REQ-005 SHALL have port op_in  input  1  operation select captured with B (0 add, 1 subtract).
REQ-006 SHALL have port load  input  1  operand load request.
REQ-007 SHALL have port clear  input  1  synchronous abort/clear request.
REQ-008 SHALL have ports a_out, b_out (output, 4) and op_out (output, 1): registered operands driven to the downstream add/subtract unit.
REQ-009 SHALL have ports r_in (input, 5), ovf_in, zero_in and sinal_in (input, 1 each): combinational result and flags returned by the add/subtract unit.
REQ-010 SHALL have ports result (output, 5), overflow, zero, sinal and valid (output, 1 each): registered result and flags.
REQ-011 SHALL have ports state (output, 2): current FSM state; op_count (output, COUNT_W): completed operations.

Function
REQ-012 SHALL define the state encoding IDLE=00, HAVE_A=01, EXEC=10, DONE=11.
REQ-013 SHALL define a "load event" per REQ-028/029 and evaluate it only at rising clk edges.
REQ-014 In IDLE, on a load event, SHALL capture a_out<=data_in and move to HAVE_A.
REQ-015 In HAVE_A, on a load event, SHALL capture b_out<=data_in and op_out<=op_in, then move to EXEC.
REQ-016 EXEC SHALL last exactly one cycle; at its closing edge the block SHALL capture result<=r_in, overflow<=ovf_in, zero<=zero_in and sinal<=sinal_in, set valid<=1, increment op_count and move to DONE.
REQ-017 Latency: with the B load event sampled at edge n, valid SHALL be 1 and result stable after edge n+1.
REQ-018 SHALL ignore load events in EXEC.
REQ-019 In DONE, the block SHALL hold all outputs; on a load event it SHALL capture a_out<=data_in, clear valid and move to HAVE_A, leaving the result registers unchanged.
REQ-020 clear SHALL take priority over load in every state: it forces IDLE and zeroes a_out, b_out, op_out, result and all flags and valid; op_count is preserved.
REQ-021 clear sampled in EXEC SHALL abort the operation: no capture and no op_count increment.
REQ-022 op_count SHALL wrap from 2^COUNT_W-1 to 0 without a flag.
REQ-023 a_out, b_out and op_out SHALL change only at the capture edges (REQ-014, REQ-015, REQ-019) or on clear and reset.
REQ-024 The block SHALL contain no arithmetic on operands; result and flags are pass-through registers of the downstream values.

Reset
REQ-025 While rst=1, the block SHALL immediately force state=IDLE and zero a_out, b_out, op_out, result, overflow, zero, sinal, valid, op_count and the load history register.
REQ-026 Reset asserted mid-operation (HAVE_A/EXEC/DONE) SHALL discard the operation with no op_count increment.
REQ-027 After rst deasserts, the first rising edge SHALL evaluate normally; a load high at that edge counts as an event only per REQ-028/029.

Configuration
REQ-028 With macro OPERAND_LOADER_LOAD_EDGE_EN defined: load event = load high at this edge and low at the previous edge (registered load_d, reset 0); a held load yields one event.
REQ-029 Without OPERAND_LOADER_LOAD_EDGE_EN: load event = load high at the edge; each high cycle is a separate event; the load_d register is absent.

Verification
REQ-030 Bench closes the loop with an adder model {ovf_in,r_in}=op?A-B:A+B, zero_in=~|r_in, sinal_in=r_in[3]. Scenario: rst, load data_in=5, load data_in=3 with op_in=0 -> one cycle later result=01000, zero=0, sinal=1, valid=1, op_count=1.
REQ-031 Loads A=3, B=3, op_in=1 -> result=00000, zero=1, valid=1; then load data_in=7 -> state=HAVE_A, valid=0, a_out=7, result still 00000.
REQ-032 clear asserted together with load in HAVE_A -> state=IDLE, a_out=b_out=0, valid=0; clear sampled in EXEC -> no valid, op_count unchanged.
REQ-033 load held high 3 cycles from IDLE with data_in=2 -> with OPERAND_LOADER_LOAD_EDGE_EN: state=HAVE_A only, a_out=2; without it: a_out=2, b_out=2, then EXEC, then DONE.
REQ-034 COUNT_W=2, 4 complete operations -> op_count sequence 1,2,3,0; rst pulse during EXEC -> all outputs 0 asynchronously, op_count=0.
